spi_ram_bridge: RTL and testbench
=================================

// Module: spi_ram_bridge
// PURPOSE
//  Parametrised, single-clock SPI-slave-to-RAM bridge; successor to the fixed 10-bit SPI+RAM wrapper.
//  Contains an internal SPI frame FSM and a single-port RAM of 2**ADDR_WIDTH x DATA_WIDTH.
//  Adds generic address and data widths, optional pointer auto-increment for bursts, and abort detection.
//  SPI bits are sampled on clk (SPI clock = system clk); sits at top level, driven by the external master.
// PARAMETERS
//  ADDR_WIDTH  8  address bits; MEM_DEPTH = 2**ADDR_WIDTH (localparam, not overridable)
//  DATA_WIDTH  8  RAM word width
//  AUTO_INC    1  1: write pointer increments after each WR_DATA; read pointer increments after each RD_DATA
//                 0: neither pointer changes
// PORTS
//  clk        in   1           system clock; all logic on rising edge
//  rst        in   1           asynchronous, active-high reset
//  SS_n       in   1           slave select, active low
//  MOSI       in   1           serial in, MSB first
//  MISO       out  1           serial out, MSB first
//  busy       out  1           1 while a frame is in progress (state != IDLE)
//  frame_err  out  1           1-cycle pulse: SS_n rose before the frame completed
// BEHAVIOUR
//  Payload width: PW = max(ADDR_WIDTH, DATA_WIDTH).
//  Bit k of a frame is MOSI sampled at the k-th rising edge with SS_n low (k=0 first).
//  Bits 0-1 are the opcode:
//   00 WR_ADDR: wptr <= payload[ADDR_WIDTH-1:0]
//   01 WR_DATA: mem[wptr] <= payload[DATA_WIDTH-1:0]
//   10 RD_ADDR: rptr <= payload[ADDR_WIDTH-1:0]
//   11 RD_DATA: read and shift out mem[rptr]; MOSI is ignored after the opcode
//  Ops 00/01/10: payload is bits 2..PW+1, MSB first; the action commits at edge PW+1; FSM goes to DONE.
//  WR_DATA with AUTO_INC=1: wptr <= wptr+1 at the commit edge, wrapping mod MEM_DEPTH (0xFF -> 0x00 at ADDR_WIDTH=8).
//  RD_DATA timing:
//   edge 1    : opcode decoded
//   edge 2    : mem[rptr] loaded into the shift register; rptr++ if AUTO_INC (wraps)
//   after edge 2+i, i=0..DATA_WIDTH-1 : MISO = data[DATA_WIDTH-1-i]
//   edge 2+DATA_WIDTH : FSM goes to DONE
//  FSM states: IDLE -> CMD (opcode) -> PAYLOAD | RD_LOAD -> RD_SHIFT -> DONE.
//   DONE holds, ignoring MOSI, until SS_n is sampled high; then -> IDLE. Extra bits never cause an error.
//  SS_n sampled high in CMD/PAYLOAD/RD_LOAD/RD_SHIFT:
//   -> IDLE next cycle; frame_err = 1 for exactly one cycle
//   no RAM write; no pointer update (RD_DATA aborted after edge 2 keeps the already-incremented rptr)
//  SS_n high in IDLE/DONE: -> IDLE, no error.
//  MISO = 0 whenever state != RD_SHIFT. busy = (state != IDLE). RAM write and read never occur in the same cycle.
//  Reset (async, any time, including mid-frame):
//   state=IDLE, MISO=0, busy=0, frame_err=0, wptr=0, rptr=0, shift registers=0
//   RAM contents are not reset and are preserved across rst
//   a frame in flight when rst asserts is discarded without frame_err
// TESTING (defaults ADDR_WIDTH=8, DATA_WIDTH=8: 10-bit frames)
//  1 rst asserted mid-WR_DATA -> MISO=0, busy=0, frame_err=0; a later RD of that address returns the old value.
//  2 WR_ADDR 0x10, WR_DATA 0xA5, WR_DATA 0x3C, RD_ADDR 0x10, RD_DATA, RD_DATA -> MISO streams 0xA5 then 0x3C.
//  3 WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22 (wrap).
//  4 WR_DATA 0x77 with SS_n raised after 5 bits -> frame_err high 1 cycle; mem and wptr unchanged.
//  5 AUTO_INC=0: RD_ADDR 0x20, RD_DATA twice -> both frames return mem[0x20]; rptr stays 0x20.
//  6 WR_ADDR frame 14 bits long -> first 10 bits used, wptr set, busy until SS_n high, frame_err=0.

Source files
------------

// File: rtl/spi_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_bridge
// Brief    : SPI-slave frame decoder in front of a single-port RAM, with
//            burst pointer auto-increment and aborted-frame detection.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module spi_ram_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AUTO_INC   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic frame_err
);
    localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int c_pw      = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int c_cw      = $clog2(c_pw);

    localparam logic [c_cw-1:0]       c_pw_last  = c_cw'(c_pw - 1);
    localparam logic [c_cw-1:0]       c_dw_last  = c_cw'(DATA_WIDTH - 1);
    localparam logic [c_cw-1:0]       c_cnt_one  = c_cw'(1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

    localparam logic [1:0] c_op_wr_addr = 2'b00;
    localparam logic [1:0] c_op_wr_data = 2'b01;
    localparam logic [1:0] c_op_rd_addr = 2'b10;
    localparam logic [1:0] c_op_rd_data = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD      = 3'd1,
        S_PAYLOAD  = 3'd2,
        S_RD_LOAD  = 3'd3,
        S_RD_SHIFT = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                  r_state;
    logic                    r_op_msb;
    logic [1:0]              r_opcode;
    logic [c_pw-2:0]         r_payload;
    logic [c_cw-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_miso;
    logic                    r_frame_err;
    logic [ADDR_WIDTH-1:0]   r_wptr;
    logic [ADDR_WIDTH-1:0]   r_rptr;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic [1:0]              w_opcode;
    logic [c_pw-1:0]         w_payload;
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic                    w_last_payload;
    logic                    w_mem_we;

    assign w_opcode       = {r_op_msb, MOSI};
    assign w_payload      = {r_payload, MOSI};
    assign w_rd_word      = r_mem[r_rptr];
    assign w_last_payload = (r_state == S_PAYLOAD) && !SS_n && (r_cnt == c_pw_last);
    assign w_mem_we       = w_last_payload && (r_opcode == c_op_wr_data);

    assign MISO      = r_miso;
    assign busy      = (r_state != S_IDLE);
    assign frame_err = r_frame_err;

    // RAM contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wptr] <= w_payload[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op_msb    <= 1'b0;
            r_opcode    <= 2'b00;
            r_payload   <= '0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_miso      <= 1'b0;
            r_frame_err <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!SS_n) begin
                        r_op_msb <= MOSI;
                        r_state  <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (SS_n) begin
                        r_state     <= S_IDLE;
                        r_frame_err <= 1'b1;
                    end else begin
                        r_opcode <= w_opcode;
                        r_cnt    <= '0;
                        r_state  <= (w_opcode == c_op_rd_data) ? S_RD_LOAD : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (SS_n) begin
                        r_state     <= S_IDLE;
                        r_frame_err <= 1'b1;
                    end else begin
                        r_payload <= w_payload[c_pw-2:0];
                        if (r_cnt == c_pw_last) begin
                            r_state <= S_DONE;
                            case (r_opcode)
                                c_op_wr_addr: r_wptr <= w_payload[ADDR_WIDTH-1:0];
                                c_op_wr_data: if (AUTO_INC != 0) r_wptr <= r_wptr + c_addr_one;
                                c_op_rd_addr: r_rptr <= w_payload[ADDR_WIDTH-1:0];
                                default: ;
                            endcase
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                end
                S_RD_LOAD: begin
                    if (SS_n) begin
                        r_state     <= S_IDLE;
                        r_frame_err <= 1'b1;
                    end else begin
                        // MSB goes out straight away; r_shift holds the remaining bits
                        r_miso  <= w_rd_word[DATA_WIDTH-1];
                        r_shift <= {w_rd_word[DATA_WIDTH-2:0], 1'b0};
                        r_cnt   <= '0;
                        if (AUTO_INC != 0) r_rptr <= r_rptr + c_addr_one;
                        r_state <= S_RD_SHIFT;
                    end
                end
                S_RD_SHIFT: begin
                    if (SS_n) begin
                        r_state     <= S_IDLE;
                        r_frame_err <= 1'b1;
                        r_miso      <= 1'b0;
                    end else if (r_cnt == c_dw_last) begin
                        r_state <= S_DONE;
                        r_miso  <= 1'b0;
                    end else begin
                        r_miso  <= r_shift[DATA_WIDTH-1];
                        r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                        r_cnt   <= r_cnt + c_cnt_one;
                    end
                end
                S_DONE: begin
                    if (SS_n) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_spi_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_ram_bridge
// Brief    : Self-checking bench for spi_ram_bridge (AUTO_INC=1 and 0 side by side).
// Revision : 1.0
// ============================================================================
module tb_spi_ram_bridge;
    logic clk, rst, SS_n, MOSI;
    logic miso1, busy1, ferr1;
    logic miso0, busy0, ferr0;

    spi_ram_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(1)) dut_inc (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(miso1), .busy(busy1), .frame_err(ferr1)
    );
    spi_ram_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(0)) dut_hold (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(miso0), .busy(busy0), .frame_err(ferr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: memory image and pointers for each variant
    logic [7:0] m1 [256];
    logic [7:0] m0 [256];
    logic [7:0] wp1, rp1, wp0, rp0;

    // Observations from the most recent frame
    logic [7:0] obs_rd1, obs_rd0;
    logic       busy1_d, busy0_d, miso1_d, miso0_d;
    logic       busy1_a, busy0_a, miso1_a, miso0_a, ferr1_a, ferr0_a;
    logic       ferr1_c, ferr0_c;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] payload;
        logic [4:0] nbits;
        logic       chk_rd;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] pl, input int nb,
                                input logic chk, input logic [7:0] rd, input logic err);
        vec_t v;
        v.op = op; v.payload = pl; v.nbits = 5'(nb);
        v.chk_rd = chk; v.exp_rd = rd; v.exp_err = err;
        return v;
    endfunction

    function automatic logic [7:0] init_val(input int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Drives nbits frame bits (bit 0 first), then raises SS_n for two edges.
    task automatic run_frame(input logic [1:0] op, input logic [7:0] pl, input int nbits);
        logic [9:0] bits;
        bits    = {op, pl};
        obs_rd1 = '0;
        obs_rd0 = '0;
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            if (k >= 3 && k <= 10) begin
                obs_rd1[10-k] = miso1;
                obs_rd0[10-k] = miso0;
            end
            SS_n = 1'b0;
            MOSI = (k < 10) ? bits[9-k] : 1'($urandom);
        end
        @(negedge clk);
        busy1_d = busy1; busy0_d = busy0; miso1_d = miso1; miso0_d = miso0;
        SS_n = 1'b1;
        MOSI = 1'($urandom);
        @(negedge clk);
        busy1_a = busy1; busy0_a = busy0; miso1_a = miso1; miso0_a = miso0;
        ferr1_a = ferr1; ferr0_a = ferr0;
        @(negedge clk);
        ferr1_c = ferr1; ferr0_c = ferr0;
    endtask

    task automatic check_frame(input logic [1:0] op, input logic [7:0] pl, input int nbits);
        int         req;
        logic       complete;
        logic [7:0] e1, e0;
        req      = (op == 2'b11) ? 11 : 10;
        complete = (nbits >= req);
        e1       = m1[rp1];
        e0       = m0[rp0];
        run_frame(op, pl, nbits);
        check("busy_in_frame", {busy1_d, busy0_d}, 2'b11);
        if (complete) check("miso_in_done", {miso1_d, miso0_d}, 2'b00);
        check("frame_err", {ferr1_a, ferr0_a}, complete ? 2'b00 : 2'b11);
        check("busy_idle", {busy1_a, busy0_a}, 2'b00);
        check("miso_idle", {miso1_a, miso0_a}, 2'b00);
        check("frame_err_clear", {ferr1_c, ferr0_c}, 2'b00);
        if (op == 2'b11 && complete) begin
            check("rd_data_inc", obs_rd1, e1);
            check("rd_data_hold", obs_rd0, e0);
        end
        if (complete) begin
            case (op)
                2'b00: begin wp1 = pl; wp0 = pl; end
                2'b01: begin m1[wp1] = pl; wp1 = wp1 + 8'd1; m0[wp0] = pl; end
                2'b10: begin rp1 = pl; rp0 = pl; end
                default: rp1 = rp1 + 8'd1;
            endcase
        end else if (op == 2'b11 && nbits >= 3) begin
            rp1 = rp1 + 8'd1;
        end
    endtask

    initial begin
        logic [9:0] pbits;
        logic [1:0] rop;
        int         rnb;

        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
        wp1 = 0; rp1 = 0; wp0 = 0; rp0 = 0;
        #2;
        check("reset_miso", {miso1, miso0}, 2'b00);
        check("reset_busy", {busy1, busy0}, 2'b00);
        check("reset_ferr", {ferr1, ferr0}, 2'b00);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Fill every location with a known pattern
        for (int a = 0; a < 256; a++) begin
            check_frame(2'b00, 8'(a), 10);
            check_frame(2'b01, init_val(a), 10);
        end

        // Burst write/read, wrap at top of memory, aborted write, long frame, aborted read
        vecs.push_back(mk(2'b00, 8'h10, 10, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(2'b01, 8'hA5, 10, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(2'b01, 8'h3C, 10, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(2'b10, 8'h10, 10, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(2'b11, 8'h00, 11, 1'b1, 8'hA5, 1'b0));
        vecs.push_back(mk(2'b11, 8'h00, 11, 1'b1, 8'h3C, 1'b0));
        vecs.push_back(mk(2'b00, 8'hFF, 10, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(2'b01, 8'h11, 10, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(2'b01, 8'h22, 10, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(2'b10, 8'hFF, 10, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(2'b11, 8'h00, 11, 1'b1, 8'h11, 1'b0));
        vecs.push_back(mk(2'b11, 8'h00, 11, 1'b1, 8'h22, 1'b0));
        vecs.push_back(mk(2'b00, 8'h30, 10, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(2'b01, 8'h77,  5, 1'b0, 8'h00, 1'b1));
        vecs.push_back(mk(2'b01, 8'h5A, 10, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(2'b10, 8'h30, 10, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(2'b11, 8'h00, 11, 1'b1, 8'h5A, 1'b0));
        vecs.push_back(mk(2'b11, 8'h00, 11, 1'b1, 8'h6B, 1'b0));
        vecs.push_back(mk(2'b00, 8'h50, 14, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(2'b01, 8'hC3, 10, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(2'b10, 8'h50, 10, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(2'b11, 8'h00, 11, 1'b1, 8'hC3, 1'b0));
        vecs.push_back(mk(2'b10, 8'h60, 10, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk(2'b11, 8'h00,  6, 1'b0, 8'h00, 1'b1));
        vecs.push_back(mk(2'b11, 8'h00, 11, 1'b1, 8'h3B, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            check_frame(vecs[i].op, vecs[i].payload, int'(vecs[i].nbits));
            check("vec_frame_err", ferr1_a, vecs[i].exp_err);
            if (vecs[i].chk_rd) check("vec_rd_data", obs_rd1, vecs[i].exp_rd);
        end

        // Non-incrementing variant re-reads the same word
        check_frame(2'b10, 8'h20, 10);
        check_frame(2'b11, 8'h00, 11);
        check("hold_rd_first", obs_rd0, 8'h7A);
        check("inc_rd_first", obs_rd1, 8'h7A);
        check_frame(2'b11, 8'h00, 11);
        check("hold_rd_second", obs_rd0, 8'h7A);
        check("inc_rd_second", obs_rd1, 8'h7B);

        // Asynchronous reset in the middle of a WR_DATA frame
        check_frame(2'b00, 8'h40, 10);
        pbits = {2'b01, 8'h99};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            SS_n = 1'b0;
            MOSI = pbits[9-k];
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_miso", {miso1, miso0}, 2'b00);
        check("midrst_busy", {busy1, busy0}, 2'b00);
        check("midrst_ferr", {ferr1, ferr0}, 2'b00);
        @(negedge clk);
        SS_n = 1'b1;
        rst  = 1'b0;
        wp1 = 0; rp1 = 0; wp0 = 0; rp0 = 0;
        @(negedge clk);
        check("postrst_ferr", {ferr1, ferr0}, 2'b00);
        check("postrst_busy", {busy1, busy0}, 2'b00);
        check_frame(2'b11, 8'h00, 11);
        check_frame(2'b10, 8'h40, 10);
        check_frame(2'b11, 8'h00, 11);
        check("midrst_old_inc", obs_rd1, 8'h1A);
        check("midrst_old_hold", obs_rd0, 8'h1A);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            rop = 2'($urandom);
            if ($urandom_range(0, 3) != 0)
                rnb = (rop == 2'b11) ? int'($urandom_range(11, 14)) : int'($urandom_range(10, 14));
            else
                rnb = (rop == 2'b11) ? int'($urandom_range(1, 10)) : int'($urandom_range(1, 9));
            check_frame(rop, 8'($urandom), rnb);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
